// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus drive arbiter: state encoding, sizing limits and clog2.
package bus_arb_pkg;

    localparam int unsigned MaxNrOfMasters = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StTurn = 2'd2
    } bus_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping modulo
// NrOfMasters.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrOfMasters = 4,
    parameter int unsigned OwnerBits   = 2
) (
    input  logic [NrOfMasters-1:0] req,
    input  logic [OwnerBits-1:0]   ptr,
    output logic                   found,
    output logic [OwnerBits-1:0]   winner
);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NrOfMasters; i++) begin
            int unsigned idx;
            idx = (int'(ptr) + i) % NrOfMasters;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = OwnerBits'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner arbiter for the shared tri-state bus with bounded hold time.
// Define BUS_ARB_TURNAROUND_EN to insert one dead bus cycle between successive owners.
module bus_drive_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrOfMasters = 4,
    parameter int unsigned MaxHold     = 16,
    parameter int unsigned OwnerBits   = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NrOfMasters-1:0] Req,
    output logic [NrOfMasters-1:0] Grant,
    output logic [NrOfMasters-1:0] Drive_T,
    output logic [OwnerBits-1:0]   Owner,
    output logic                   Busy
);

    localparam int unsigned HcBits = (clog2(MaxHold + 1) == 0) ? 1 : clog2(MaxHold + 1);

    bus_state_e             state_q, state_d;
    logic [NrOfMasters-1:0] grant_q, grant_d;
    logic [OwnerBits-1:0]   owner_q, owner_d;
    logic                   busy_q, busy_d;
    logic [OwnerBits-1:0]   ptr_q, ptr_d;
    logic [HcBits-1:0]      hc_q, hc_d;

    logic [OwnerBits-1:0]   next_ptr;
    logic [OwnerBits-1:0]   pick_ptr;
    logic                   found;
    logic [OwnerBits-1:0]   winner;
    logic [NrOfMasters-1:0] other_req;
    logic                   release_own;
    logic                   preempt_own;

    rr_priority_pick #(
        .NrOfMasters (NrOfMasters),
        .OwnerBits   (OwnerBits)
    ) u_pick (
        .req    (Req),
        .ptr    (pick_ptr),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        next_ptr = (owner_q == OwnerBits'(NrOfMasters - 1)) ? '0 : owner_q + 1'b1;
        // While owning, the next winner is searched from the post-release pointer.
        pick_ptr = (state_q == StOwn) ? next_ptr : ptr_q;

        other_req          = Req;
        other_req[owner_q] = 1'b0;
        release_own        = !Req[owner_q];
        // >= rather than == so a waiter arriving after saturation is still served.
        preempt_own        = (MaxHold != 0) && (hc_q >= HcBits'(MaxHold - 1)) && |other_req;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        hc_d    = hc_q;

        unique case (state_q)
            StIdle, StTurn: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = StIdle;
                if (found) begin
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    busy_d          = 1'b1;
                    hc_d            = '0;
                    state_d         = StOwn;
                end
            end
            StOwn: begin
                if (hc_q != HcBits'(MaxHold)) begin
                    hc_d = hc_q + 1'b1;
                end
                if (release_own || preempt_own) begin
                    ptr_d   = next_ptr;
                    grant_d = '0;
                    busy_d  = 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
                    state_d = StTurn;
`else
                    state_d = StIdle;
                    if (found) begin
                        grant_d[winner] = 1'b1;
                        owner_d         = winner;
                        busy_d          = 1'b1;
                        hc_d            = '0;
                        state_d         = StOwn;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hc_q    <= hc_d;
        end
    end

    assign Grant   = grant_q;
    assign Drive_T = grant_q;
    assign Owner   = owner_q;
    assign Busy    = busy_q;

endmodule
